// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control FSM and its ALU decoder.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_EXC
   } state_t;

   typedef enum logic [2:0] {
      CL_ALU_R, CL_ALU_I, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JR
   } class_t;

   localparam logic [3:0] ALU_ADD  = 4'b1110;
   localparam logic [3:0] ALU_SUB  = 4'b0100;
   localparam logic [3:0] ALU_ADDU = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1010;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;
   localparam logic [3:0] ALU_LUI  = 4'b0110;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;

   localparam logic [4:0] EXC_BUS = 5'd6;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OVF = 5'd12;

   localparam logic [1:0] SRC_A_PC     = 2'd0;
   localparam logic [1:0] SRC_A_RS     = 2'd1;
   localparam logic [1:0] SRC_A_SHAMT  = 2'd2;
   localparam logic [1:0] SRC_B_RT     = 2'd0;
   localparam logic [1:0] SRC_B_FOUR   = 2'd1;
   localparam logic [1:0] SRC_B_IMM    = 2'd2;
   localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_RS     = 2'd3;

   function automatic logic is_shift(input logic [3:0] ctr);
      return (ctr == ALU_SLL) || (ctr == ALU_SRL) || (ctr == ALU_SRA);
   endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational opcode/funct classifier: ALU code, instruction class, illegal flag.
module mc_alu_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [3:0] alu_ctr,
   output class_t     cls,
   output logic       illegal
);

   always_comb begin
      alu_ctr = ALU_ADDU;
      cls     = CL_ALU_R;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_ctr = ALU_ADD;
               FN_ADDU: alu_ctr = ALU_ADDU;
               FN_SUB:  alu_ctr = ALU_SUB;
               FN_AND:  alu_ctr = ALU_AND;
               FN_OR:   alu_ctr = ALU_OR;
               FN_XOR:  alu_ctr = ALU_XOR;
               FN_SLL:  alu_ctr = ALU_SLL;
               FN_SRL:  alu_ctr = ALU_SRL;
               FN_SRA:  alu_ctr = ALU_SRA;
               FN_JR:   cls     = CL_JR;
               default: illegal = 1'b1;
            endcase
         end
         OP_ADDI:  begin cls = CL_ALU_I; alu_ctr = ALU_ADD;  end
         OP_ADDIU: begin cls = CL_ALU_I; alu_ctr = ALU_ADDU; end
         OP_ANDI:  begin cls = CL_ALU_I; alu_ctr = ALU_AND;  end
         OP_ORI:   begin cls = CL_ALU_I; alu_ctr = ALU_OR;   end
         OP_XORI:  begin cls = CL_ALU_I; alu_ctr = ALU_XOR;  end
         OP_LUI:   begin cls = CL_ALU_I; alu_ctr = ALU_LUI;  end
         OP_LW:    cls = CL_LW;
         OP_SW:    cls = CL_SW;
         OP_BEQ:   begin cls = CL_BEQ; alu_ctr = ALU_SUB; end
         OP_BNE:   begin cls = CL_BNE; alu_ctr = ALU_SUB; end
         OP_J:     cls = CL_J;
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit driving the ALU and datapath.
// Optional perf counters (cyc_cnt, ret_cnt) are built when MC_CTRL_PERF_CNT_EN is defined.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W  = 32,
   parameter int MEM_TO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        alu_zero,
   input  logic        alu_overflow,
   output logic [3:0]  alu_ctr,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        reg_we,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        exc_valid,
   output logic [4:0]  exc_code
`ifdef MC_CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ret_cnt
`endif
);

   localparam int WD_W    = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
   localparam int WD_LAST = (MEM_TO > 0) ? MEM_TO - 1 : 0;

   state_t     state;
   logic [4:0] exc_q;
   logic [3:0] dec_ctr;
   class_t     cls;
   logic       illegal;
   logic       ovf_chk;
   logic       waiting;
   logic       wd_expire;
   logic       unused_instr;

   assign unused_instr = ^instr[25:6];

   mc_alu_decode u_dec (
      .opcode  (instr[31:26]),
      .funct   (instr[5:0]),
      .alu_ctr (dec_ctr),
      .cls     (cls),
      .illegal (illegal)
   );

   // Only signed ALU ops trap; branch SUB and unsigned ops ignore alu_overflow.
   assign ovf_chk = ((cls == CL_ALU_R) || (cls == CL_ALU_I)) &&
                    ((dec_ctr == ALU_ADD) || (dec_ctr == ALU_SUB));
   assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;

   generate
      if (MEM_TO > 0) begin : g_wd
         logic [WD_W-1:0] wd_cnt;
         // Any exit from a waiting state clears the count, so every entry starts at 0.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)                       wd_cnt <= '0;
            else if (waiting && !wd_expire) wd_cnt <= wd_cnt + 1'b1;
            else                           wd_cnt <= '0;
         end
         assign wd_expire = waiting && (wd_cnt == WD_W'(WD_LAST));
      end else begin : g_no_wd
         assign wd_expire = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
         exc_q <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) state <= S_DECODE;
               else if (wd_expire) begin state <= S_EXC; exc_q <= EXC_BUS; end
            end
            S_DECODE: begin
               if (illegal) begin state <= S_EXC; exc_q <= EXC_RI; end
               else if ((cls == CL_J) || (cls == CL_JR)) state <= S_FETCH;
               else state <= S_EXEC;
            end
            S_EXEC: begin
               case (cls)
                  CL_LW, CL_SW:   state <= S_MEM;
                  CL_BEQ, CL_BNE: state <= S_FETCH;
                  default: begin
                     if (ovf_chk && alu_overflow) begin
                        state <= S_EXC;
                        exc_q <= EXC_OVF;
                     end else state <= S_WB;
                  end
               endcase
            end
            S_MEM: begin
               if (mem_ready) state <= (cls == CL_SW) ? S_FETCH : S_WB;
               else if (wd_expire) begin state <= S_EXC; exc_q <= EXC_BUS; end
            end
            default: state <= S_FETCH;
         endcase
      end
   end

   // Outputs decode the registered state; reset forces the idle pattern immediately.
   always_comb begin
      alu_ctr    = ALU_ADDU;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RT;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PC_SRC_ALU;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      exc_valid  = 1'b0;
      exc_code   = '0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = SRC_B_FOUR;
               ir_we     = mem_ready;
               pc_we     = mem_ready;
            end
            S_DECODE: begin
               alu_src_b = SRC_B_IMM_SH;
               if (!illegal && (cls == CL_J)) begin
                  pc_we  = 1'b1;
                  pc_src = PC_SRC_JUMP;
               end else if (!illegal && (cls == CL_JR)) begin
                  pc_we  = 1'b1;
                  pc_src = PC_SRC_RS;
               end
            end
            S_EXEC: begin
               alu_ctr   = dec_ctr;
               alu_src_a = is_shift(dec_ctr) ? SRC_A_SHAMT : SRC_A_RS;
               alu_src_b = ((cls == CL_ALU_R) || (cls == CL_BEQ) || (cls == CL_BNE))
                           ? SRC_B_RT : SRC_B_IMM;
               if ((cls == CL_BEQ) || (cls == CL_BNE)) begin
                  pc_src = PC_SRC_ALUOUT;
                  pc_we  = (cls == CL_BEQ) ? alu_zero : !alu_zero;
               end
            end
            S_MEM: begin
               mem_req = 1'b1;
               mem_we  = (cls == CL_SW);
            end
            S_WB: begin
               reg_we     = 1'b1;
               reg_dst    = (cls == CL_ALU_R);
               mem_to_reg = (cls == CL_LW);
            end
            S_EXC: begin
               exc_valid = 1'b1;
               exc_code  = exc_q;
            end
            default: ;
         endcase
      end
   end

`ifdef MC_CTRL_PERF_CNT_EN
   logic retire;
   assign retire = (state == S_WB) ||
                   ((state == S_MEM) && mem_ready && (cls == CL_SW)) ||
                   ((state == S_EXEC) && ((cls == CL_BEQ) || (cls == CL_BNE))) ||
                   ((state == S_DECODE) && !illegal && ((cls == CL_J) || (cls == CL_JR)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt <= '0;
         ret_cnt <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + CNT_W'(1);
         if (retire) ret_cnt <= ret_cnt + CNT_W'(1);
      end
   end
`else
   localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed table-driven bench for mc_ctrl_fsm (MEM_TO=4); perf counters checked when enabled.
module tb_mc_ctrl_fsm;

   typedef struct packed {
      logic [3:0] alu_ctr;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic       mem_req;
      logic       mem_we;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       reg_we;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       exc_valid;
      logic [4:0] exc_code;
   } out_t;

   typedef struct {
      logic [31:0] ins;
      logic        rdy;
      logic        zero;
      logic        ovf;
      out_t        exp;
   } row_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = '0;
   logic        mem_ready = 1'b0;
   logic        alu_zero = 1'b0;
   logic        alu_overflow = 1'b0;
   logic [3:0]  alu_ctr;
   logic [1:0]  alu_src_a, alu_src_b, pc_src;
   logic        mem_req, mem_we, ir_we, pc_we, reg_we, reg_dst, mem_to_reg, exc_valid;
   logic [4:0]  exc_code;
`ifdef MC_CTRL_PERF_CNT_EN
   logic [7:0]  cyc_cnt, ret_cnt;
`endif

   int n_run = 0;
   int n_fail = 0;
   row_t tbl[$];

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.CNT_W(8), .MEM_TO(4)) dut (
      .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
      .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .alu_ctr(alu_ctr), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
      .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .exc_valid(exc_valid), .exc_code(exc_code)
`ifdef MC_CTRL_PERF_CNT_EN
      , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
   );

   function automatic out_t base();
      out_t o = '0;
      o.alu_ctr = 4'b0001;
      return o;
   endfunction
   function automatic out_t fF(input logic r);
      out_t o = base();
      o.src_b = 2'd1; o.mem_req = 1'b1; o.ir_we = r; o.pc_we = r;
      return o;
   endfunction
   function automatic out_t fD(input logic we, input logic [1:0] src);
      out_t o = base();
      o.src_b = 2'd3; o.pc_we = we; o.pc_src = src;
      return o;
   endfunction
   function automatic out_t fE(input logic [3:0] c, input logic [1:0] a, input logic [1:0] b,
                               input logic we, input logic [1:0] src);
      out_t o = base();
      o.alu_ctr = c; o.src_a = a; o.src_b = b; o.pc_we = we; o.pc_src = src;
      return o;
   endfunction
   function automatic out_t fM(input logic we);
      out_t o = base();
      o.mem_req = 1'b1; o.mem_we = we;
      return o;
   endfunction
   function automatic out_t fW(input logic dst, input logic m2r);
      out_t o = base();
      o.reg_we = 1'b1; o.reg_dst = dst; o.mem_to_reg = m2r;
      return o;
   endfunction
   function automatic out_t fX(input logic [4:0] code);
      out_t o = base();
      o.exc_valid = 1'b1; o.exc_code = code;
      return o;
   endfunction

   function automatic out_t sample();
      out_t o;
      o.alu_ctr = alu_ctr; o.src_a = alu_src_a; o.src_b = alu_src_b;
      o.mem_req = mem_req; o.mem_we = mem_we; o.ir_we = ir_we; o.pc_we = pc_we;
      o.pc_src = pc_src; o.reg_we = reg_we; o.reg_dst = reg_dst;
      o.mem_to_reg = mem_to_reg; o.exc_valid = exc_valid; o.exc_code = exc_code;
      return o;
   endfunction

   task automatic push(input logic [31:0] i, input logic r, input logic z, input logic v,
                       input out_t e);
      row_t t;
      t.ins = i; t.rdy = r; t.zero = z; t.ovf = v; t.exp = e;
      tbl.push_back(t);
   endtask

   // Register-writing ALU op: F, D, E, W with zero-wait fetch.
   task automatic alu4(input logic [31:0] i, input logic [3:0] c, input logic [1:0] a,
                       input logic [1:0] b, input logic dst, input logic v);
      push(i, 1, 0, 0, fF(1));
      push(i, 0, 0, 0, fD(0, 0));
      push(i, 0, 0, v, fE(c, a, b, 0, 0));
      push(i, 0, 0, 0, fW(dst, 0));
   endtask

   task automatic br3(input logic [31:0] i, input logic z, input logic v, input logic tk);
      push(i, 1, 0, 0, fF(1));
      push(i, 0, 0, 0, fD(0, 0));
      push(i, 0, z, v, fE(4'b0100, 1, 0, tk, 1));
   endtask

   task automatic check(input string name, input out_t act, input out_t exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic run_row(input row_t t, input string name);
      instr = t.ins; mem_ready = t.rdy; alu_zero = t.zero; alu_overflow = t.ovf;
      @(negedge clk);
      check(name, sample(), t.exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // add $3,$1,$2
      alu4(32'h00221820, 4'b1110, 1, 0, 1, 0);
      alu4(32'h00221822, 4'b0100, 1, 0, 1, 0);   // sub
      alu4(32'h00221821, 4'b0001, 1, 0, 1, 1);   // addu, overflow ignored
      alu4(32'h00221824, 4'b0010, 1, 0, 1, 0);   // and
      alu4(32'h00221825, 4'b0011, 1, 0, 1, 0);   // or
      alu4(32'h00221826, 4'b0111, 1, 0, 1, 0);   // xor
      alu4(32'h00021080, 4'b1010, 2, 0, 1, 0);   // sll
      alu4(32'h00021082, 4'b1000, 2, 0, 1, 0);   // srl
      alu4(32'h00021083, 4'b1001, 2, 0, 1, 0);   // sra
      alu4(32'h20220005, 4'b1110, 1, 2, 0, 0);   // addi
      alu4(32'h24220005, 4'b0001, 1, 2, 0, 1);   // addiu, overflow ignored
      alu4(32'h30220005, 4'b0010, 1, 2, 0, 0);   // andi
      alu4(32'h34220005, 4'b0011, 1, 2, 0, 0);   // ori
      alu4(32'h38220005, 4'b0111, 1, 2, 0, 0);   // xori
      alu4(32'h3C020005, 4'b0110, 1, 2, 0, 0);   // lui
      br3(32'h10220004, 1, 0, 1);                // beq taken
      br3(32'h10220004, 0, 0, 0);                // beq not taken
      br3(32'h14220004, 0, 1, 1);                // bne taken, overflow ignored
      br3(32'h14220004, 1, 0, 0);                // bne not taken
      // addi overflow -> EXC 12, no reg_we
      push(32'h20220005, 1, 0, 0, fF(1));
      push(32'h20220005, 0, 0, 0, fD(0, 0));
      push(32'h20220005, 0, 0, 1, fE(4'b1110, 1, 2, 0, 0));
      push(32'h20220005, 0, 0, 0, fX(5'd12));
      // sub overflow -> EXC 12
      push(32'h00221822, 1, 0, 0, fF(1));
      push(32'h00221822, 0, 0, 0, fD(0, 0));
      push(32'h00221822, 0, 0, 1, fE(4'b0100, 1, 0, 0, 0));
      push(32'h00221822, 0, 0, 0, fX(5'd12));
      // lw with a fetch wait and 3 MEM waits (ready on the would-be timeout cycle)
      push(32'h8C220008, 0, 0, 0, fF(0));
      push(32'h8C220008, 1, 0, 0, fF(1));
      push(32'h8C220008, 0, 0, 0, fD(0, 0));
      push(32'h8C220008, 0, 0, 0, fE(4'b0001, 1, 2, 0, 0));
      for (int k = 0; k < 3; k++) push(32'h8C220008, 0, 0, 0, fM(0));
      push(32'h8C220008, 1, 0, 0, fM(0));
      push(32'h8C220008, 0, 0, 0, fW(0, 1));
      // sw
      push(32'hAC220008, 1, 0, 0, fF(1));
      push(32'hAC220008, 0, 0, 0, fD(0, 0));
      push(32'hAC220008, 0, 0, 0, fE(4'b0001, 1, 2, 0, 0));
      push(32'hAC220008, 1, 0, 0, fM(1));
      // j, jr
      push(32'h08000010, 1, 0, 0, fF(1));
      push(32'h08000010, 0, 0, 0, fD(1, 2));
      push(32'h03E00008, 1, 0, 0, fF(1));
      push(32'h03E00008, 0, 0, 0, fD(1, 3));
      // reserved opcode 3F, reserved funct 3F
      push(32'hFC000000, 1, 0, 0, fF(1));
      push(32'hFC000000, 0, 0, 0, fD(0, 0));
      push(32'hFC000000, 0, 0, 0, fX(5'd10));
      push(32'h0000003F, 1, 0, 0, fF(1));
      push(32'h0000003F, 0, 0, 0, fD(0, 0));
      push(32'h0000003F, 0, 0, 0, fX(5'd10));
      // fetch timeout after 4 waiting cycles
      for (int k = 0; k < 4; k++) push(32'h0, 0, 0, 0, fF(0));
      push(32'h0, 0, 0, 0, fX(5'd6));
      // MEM timeout
      push(32'h8C220008, 1, 0, 0, fF(1));
      push(32'h8C220008, 0, 0, 0, fD(0, 0));
      push(32'h8C220008, 0, 0, 0, fE(4'b0001, 1, 2, 0, 0));
      for (int k = 0; k < 4; k++) push(32'h8C220008, 0, 0, 0, fM(0));
      push(32'h8C220008, 0, 0, 0, fX(5'd6));
      push(32'h0, 0, 0, 0, fF(0));

      @(negedge clk);
      check("reset_outputs", sample(), base());
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], $sformatf("row%0d", i));

      // Reset asserted mid-MEM of a lw
      tbl.delete();
      push(32'h8C220008, 1, 0, 0, fF(1));
      push(32'h8C220008, 0, 0, 0, fD(0, 0));
      push(32'h8C220008, 0, 0, 0, fE(4'b0001, 1, 2, 0, 0));
      for (int i = 0; i < 3; i++) run_row(tbl[i], $sformatf("rstseq%0d", i));
      instr = 32'h8C220008; mem_ready = 1'b0;
      #2 check("mem_before_rst", sample(), fM(0));
      rst = 1'b1;
      #1 check("mem_rst_immediate", sample(), base());
`ifdef MC_CTRL_PERF_CNT_EN
      n_run++;
      if (cyc_cnt !== 8'd0 || ret_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL perf_reset: got=%0d/%0d want=0/0", cyc_cnt, ret_cnt);
      end
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      tbl.delete();
      push(32'h0, 0, 0, 0, fF(0));
      alu4(32'h00221820, 4'b1110, 1, 0, 1, 0);
      for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], $sformatf("post_rst%0d", i));
`ifdef MC_CTRL_PERF_CNT_EN
      n_run++;
      if (cyc_cnt !== 8'd5 || ret_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL perf_count: got=%0d/%0d want=5/1", cyc_cnt, ret_cnt);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
